t5_dmem: RTL and testbench
==========================

Name: t5_dmem

Overview:
- Data-memory access stage of the tra5 barrel pipeline; sits directly upstream of the writeback stage.
- Takes the execute-stage address/store data and opcode, then drives the data Wishbone master port (dwb_*).
- Provides the writeback stage with the byte-lane select and strobe/write qualifiers it needs to extend load data.
- Stalls the pipeline while a bus cycle is outstanding and aborts on misalignment or bus timeout.

Parameters:
XLEN, 32, datapath width (only 32 supported)
TMO, 15, cycles without dwb_ack before a bus cycle is aborted (1..255)

Ports:
sclk  in  1  clock
srst  in  1  reset, asynchronous, active-low
sena  in  1  pipeline advance enable
xopc  in  5  [6:2] opcode of instruction in execute
xfn3  in  3  [14:12] funct3 of instruction in execute
xalu  in  XLEN  effective address from ALU
xrs2  in  XLEN  store data (rs2)
dwb_ack  in  1  Wishbone acknowledge
dwb_adr  out  XLEN  word address, [1:0] forced 0
dwb_dto  out  XLEN  store data, lane-replicated
dwb_sel  out  4  byte-lane select
dwb_stb  out  1  Wishbone strobe/cycle
dwb_wre  out  1  Wishbone write enable
xsel  out  4  lane select to writeback (equals dwb_sel)
xstb  out  1  strobe to writeback (equals dwb_stb)
xwre  out  1  write qualifier to writeback (equals dwb_wre)
dstall  out  1  pipeline hold request
dmis  out  1  one-cycle misaligned-access flag
dberr  out  1  one-cycle bus-timeout flag

Behaviour:
- Decode: load is xopc==5'b00000; store is xopc==5'b01000; all other opcodes generate no bus activity.
- Size comes from xfn3[13:12]: 00 byte, 01 half, 10 word; 11 is treated as misaligned.
- Lane select: byte gives 4'b0001<<xalu[1:0]. Half gives 4'h3 when xalu[1]=0, else 4'hC. Word gives 4'hF.
- Alignment: half requires xalu[0]=0; word requires xalu[1:0]=0.
- Store data: byte is replicated 4x from xrs2[7:0], half 2x from xrs2[15:0], word passes through. Unselected lanes are don't-care but driven.
- FSM states are IDLE and BUSY. All dwb_* outputs, flags and the state are registered.
- IDLE, sena=1, aligned mem op: on the next edge register adr/sel/dto/wre, set dwb_stb=1, clear the timeout counter, go to BUSY.
- IDLE, sena=1, misaligned mem op: on the next edge dmis=1 for one cycle. No strobe; stay in IDLE.
- IDLE, sena=0 or no mem op: dwb_stb=0 and outputs hold their values.
- BUSY: dstall = !dwb_ack (combinational). The counter increments each cycle without ack.
- BUSY with dwb_ack=1: dstall=0 that cycle, and xsel/xstb/xwre stay valid that same cycle for the writeback stage.
  - Next edge: if sena=1 and the execute stage holds an aligned mem op, reload directly and stay in BUSY (back-to-back, no idle gap).
  - Otherwise dwb_stb=0 and go to IDLE.
- BUSY, counter reaches TMO with no ack: the next edge drops dwb_stb, sets dberr=1 for one cycle and goes to IDLE. dstall is 0 in the abort cycle.
- Ack and timeout in the same cycle: ack wins, and dberr stays 0.
- dwb_ack while in IDLE is ignored.
- dstall is 0 in IDLE.
- Reset (srst=0, any time including mid-cycle BUSY): immediately dwb_stb=0, dwb_wre=0, dwb_sel=0, dwb_adr=0, dwb_dto=0, dmis=0, dberr=0, counter=0, state=IDLE.
- Output latency: first strobe appears 1 cycle after the enabling edge; minimum bus cycle is 1 cycle (zero-wait ack).

Test Plan:
- Word load, xalu=0x100, xfn3=010, ack after 3 cycles: dwb_adr=0x100, sel=F, wre=0, dstall=1 for 2 cycles then 0 with ack; stb drops next cycle.
- Byte store, xalu=0x203, xrs2=0xA5, xfn3=000, zero-wait ack: sel=8, dto=0xA5A5A5A5, wre=1, dstall never 1.
- Half load at 0x302: sel=C. Half load at 0x301: no stb, dmis=1 for exactly one cycle.
- Back-to-back word loads with immediate ack each cycle: stb stays high, adr updates every cycle, no IDLE cycle.
- No ack for TMO=15 cycles: dstall high 15 cycles, then stb=0 and dberr=1 for one cycle; ack arriving on cycle 15 yields no dberr.
- srst low while BUSY: stb/wre/sel drop without a clock edge; after release, first mem op behaves as from clean IDLE.

Source files
------------

// File: rtl/t5_dmem.sv
// -----------------------------------------------------------------------------
// t5_dmem -- data-memory access stage of the tra5 barrel pipeline.
//
// Decodes load/store instructions held in execute, checks their alignment and
// runs one Wishbone classic cycle per access on the data master port. It holds
// the pipeline (dstall) while a cycle is outstanding and aborts the cycle if
// no acknowledge arrives within TMO cycles. The writeback stage receives the
// byte-lane select and strobe/write qualifiers so it can extend load data.
//
// Ports
//   sclk, srst           clock, asynchronous active-low reset
//   sena                 pipeline advance enable
//   xopc, xfn3           opcode [6:2] and funct3 [14:12] of the execute instr
//   xalu, xrs2           effective address and store data
//   dwb_ack              Wishbone acknowledge
//   dwb_adr/dto/sel      word address, lane-replicated store data, lane select
//   dwb_stb, dwb_wre     Wishbone strobe/cycle and write enable
//   xsel, xstb, xwre     copies of dwb_sel/dwb_stb/dwb_wre for writeback
//   dstall               pipeline hold request (combinational)
//   dmis, dberr          one-cycle misaligned / bus-timeout flags
// -----------------------------------------------------------------------------
module t5_dmem #(
   parameter int XLEN = 32,
   parameter int TMO  = 15
) (
   input  logic            sclk,
   input  logic            srst,
   input  logic            sena,
   input  logic [4:0]      xopc,
   input  logic [2:0]      xfn3,
   input  logic [XLEN-1:0] xalu,
   input  logic [XLEN-1:0] xrs2,
   input  logic            dwb_ack,
   output logic [XLEN-1:0] dwb_adr,
   output logic [XLEN-1:0] dwb_dto,
   output logic [3:0]      dwb_sel,
   output logic            dwb_stb,
   output logic            dwb_wre,
   output logic [3:0]      xsel,
   output logic            xstb,
   output logic            xwre,
   output logic            dstall,
   output logic            dmis,
   output logic            dberr
);

   localparam logic [4:0] OPC_LOAD  = 5'b00000;
   localparam logic [4:0] OPC_STORE = 5'b01000;
   localparam logic [7:0] TMO_C     = 8'(TMO);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t          state;
   state_t          state_nxt;
   logic [7:0]      cnt;

   logic            is_st_p0;
   logic            mem_op_p0;
   logic            aligned_p0;
   logic [3:0]      sel_p0;
   logic [XLEN-1:0] dto_p0;
   logic            accept;
   logic            issue;
   logic            misal;
   logic            tmo_hit;
   logic            abort;
   logic            hold_stb;

   // funct3[14] selects sign/zero extension, which is the writeback stage's job
   logic            unused_fn3;
   assign unused_fn3 = xfn3[2];

   // Replicate the store operand across every lane it may land in, so the
   // selected lanes always carry the right bytes whatever the address offset.
   function automatic logic [XLEN-1:0] lane_rep(input logic [1:0]      size,
                                                 input logic [XLEN-1:0] d);
      case (size)
         2'b00:   return {4{d[7:0]}};
         2'b01:   return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

   // ---- decode of the instruction in execute (p0) ----
   always_comb begin
      is_st_p0   = (xopc == OPC_STORE);
      mem_op_p0  = (xopc == OPC_LOAD) || is_st_p0;
      sel_p0     = 4'hF;
      aligned_p0 = 1'b0;
      case (xfn3[1:0])
         2'b00: begin
            sel_p0     = 4'b0001 << xalu[1:0];
            aligned_p0 = 1'b1;
         end
         2'b01: begin
            sel_p0     = xalu[1] ? 4'hC : 4'h3;
            aligned_p0 = ~xalu[0];
         end
         2'b10: begin
            sel_p0     = 4'hF;
            aligned_p0 = (xalu[1:0] == 2'b00);
         end
         default: begin
            sel_p0     = 4'hF;
            aligned_p0 = 1'b0;
         end
      endcase
      dto_p0 = lane_rep(xfn3[1:0], xrs2);
   end

   // ---- bus control: next state and combinational stall ----
   always_comb begin
      state_nxt = state;
      // The counter stops at TMO, so equality marks the abort cycle.
      tmo_hit   = (state == BUSY) && (cnt == TMO_C);
      // The stage can take a new instruction when idle or when the current
      // cycle is being acknowledged; the pipeline advances in both cases, so
      // misalignment is flagged for any accepted access.
      accept    = sena && ((state == IDLE) || dwb_ack);
      issue     = accept && mem_op_p0 && aligned_p0;
      misal     = accept && mem_op_p0 && !aligned_p0;
      // Acknowledge takes priority over a coincident timeout.
      abort     = (state == BUSY) && !dwb_ack && tmo_hit;
      hold_stb  = (state == BUSY) && !dwb_ack && !tmo_hit;
      dstall    = hold_stb;
      case (state)
         IDLE:    if (issue) state_nxt = BUSY;
         BUSY: begin
            if (dwb_ack)      state_nxt = issue ? BUSY : IDLE;
            else if (tmo_hit) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---- registered bus outputs (p1) ----
   always_ff @(posedge sclk or negedge srst) begin
      if (!srst) begin
         state   <= IDLE;
         cnt     <= 8'd0;
         dwb_adr <= '0;
         dwb_dto <= '0;
         dwb_sel <= 4'h0;
         dwb_stb <= 1'b0;
         dwb_wre <= 1'b0;
         dmis    <= 1'b0;
         dberr   <= 1'b0;
      end else begin
         state <= state_nxt;
         dmis  <= misal;
         dberr <= abort;
         if (issue) begin
            dwb_adr <= {xalu[XLEN-1:2], 2'b00};
            dwb_dto <= dto_p0;
            dwb_sel <= sel_p0;
            dwb_wre <= is_st_p0;
            dwb_stb <= 1'b1;
            cnt     <= 8'd0;
         end else begin
            dwb_stb <= hold_stb;
            if (hold_stb) cnt <= cnt + 8'd1;
         end
      end
   end

   assign xsel = dwb_sel;
   assign xstb = dwb_stb;
   assign xwre = dwb_wre;

endmodule

// File: tb/tb_t5_dmem.sv
// -----------------------------------------------------------------------------
// tb_t5_dmem -- self-checking bench for t5_dmem. A transaction-level model of
// the access stage predicts every output each cycle; directed scenarios are
// followed by a long randomized run with varying acknowledge behaviour.
// -----------------------------------------------------------------------------
module tb_t5_dmem;

   localparam int TMO = 15;
   localparam logic [4:0] LD  = 5'b00000;
   localparam logic [4:0] ST  = 5'b01000;
   localparam logic [4:0] NOP = 5'b00100;

   logic        sclk;
   logic        srst;
   logic        sena;
   logic [4:0]  xopc;
   logic [2:0]  xfn3;
   logic [31:0] xalu;
   logic [31:0] xrs2;
   logic        dwb_ack;
   logic [31:0] dwb_adr;
   logic [31:0] dwb_dto;
   logic [3:0]  dwb_sel;
   logic        dwb_stb;
   logic        dwb_wre;
   logic [3:0]  xsel;
   logic        xstb;
   logic        xwre;
   logic        dstall;
   logic        dmis;
   logic        dberr;

   t5_dmem #(.XLEN(32), .TMO(TMO)) dut (
      .sclk(sclk), .srst(srst), .sena(sena), .xopc(xopc), .xfn3(xfn3),
      .xalu(xalu), .xrs2(xrs2), .dwb_ack(dwb_ack),
      .dwb_adr(dwb_adr), .dwb_dto(dwb_dto), .dwb_sel(dwb_sel),
      .dwb_stb(dwb_stb), .dwb_wre(dwb_wre), .xsel(xsel), .xstb(xstb),
      .xwre(xwre), .dstall(dstall), .dmis(dmis), .dberr(dberr)
   );

   initial sclk = 1'b0;
   always #5 sclk = ~sclk;

   int n_vec = 0;
   int n_bad = 0;

   // model of the access stage: the outstanding transaction and its age
   bit          m_busy;
   int          m_age;
   logic [31:0] m_adr;
   logic [31:0] m_dto;
   logic [3:0]  m_sel;
   logic        m_stb;
   logic        m_wre;
   logic        m_dmis;
   logic        m_dberr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   task automatic m_reset();
      m_busy = 0; m_age = 0; m_adr = '0; m_dto = '0; m_sel = '0;
      m_stb = 0; m_wre = 0; m_dmis = 0; m_dberr = 0;
   endtask

   task automatic check_all();
      chk("stb",    {31'd0, dwb_stb}, {31'd0, m_stb});
      chk("adr",    dwb_adr, m_adr);
      chk("dto",    dwb_dto, m_dto);
      chk("sel",    {28'd0, dwb_sel}, {28'd0, m_sel});
      chk("wre",    {31'd0, dwb_wre}, {31'd0, m_wre});
      chk("xsel",   {28'd0, xsel}, {28'd0, m_sel});
      chk("xstb",   {31'd0, xstb}, {31'd0, m_stb});
      chk("xwre",   {31'd0, xwre}, {31'd0, m_wre});
      chk("dstall", {31'd0, dstall},
          {31'd0, m_busy && !dwb_ack && (m_age != TMO)});
      chk("dmis",   {31'd0, dmis}, {31'd0, m_dmis});
      chk("dberr",  {31'd0, dberr}, {31'd0, m_dberr});
   endtask

   // advance the model across one clock edge using the applied inputs
   task automatic m_step();
      bit free;
      int nbytes;
      free    = !m_busy || dwb_ack;
      m_dmis  = 0;
      m_dberr = 0;
      if (m_busy && !dwb_ack) begin
         if (m_age == TMO) begin
            m_busy = 0; m_stb = 0; m_dberr = 1;
         end else begin
            m_age++;
         end
      end
      if (free) begin
         if (sena && (xopc == LD || xopc == ST)) begin
            nbytes = 1 << xfn3[1:0];
            if (nbytes <= 4 && (xalu % nbytes) == 0) begin
               m_busy = 1; m_age = 0; m_stb = 1;
               m_adr  = xalu & ~32'd3;
               m_wre  = (xopc == ST);
               case (nbytes)
                  1: begin
                     m_sel = 4'(32'd1 << (xalu % 4));
                     m_dto = xrs2[7:0] * 32'h01010101;
                  end
                  2: begin
                     m_sel = 4'(32'd3 << (xalu & 32'd2));
                     m_dto = xrs2[15:0] * 32'h00010001;
                  end
                  default: begin
                     m_sel = 4'hF;
                     m_dto = xrs2;
                  end
               endcase
            end else begin
               m_dmis = 1; m_busy = 0; m_stb = 0;
            end
         end else begin
            m_busy = 0; m_stb = 0;
         end
      end
   endtask

   // one clock: drive between edges, check, then let the edge happen
   task automatic cyc(input bit en, input logic [4:0] opc, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d, input bit ack);
      @(negedge sclk);
      srst = 1'b1;
      sena = en; xopc = opc; xfn3 = f3; xalu = a; xrs2 = d; dwb_ack = ack;
      #1;
      check_all();
      @(posedge sclk);
      m_step();
   endtask

   // assert reset between clock edges and confirm outputs clear at once
   task automatic mid_reset();
      @(negedge sclk);
      sena = 1'b0; dwb_ack = 1'b0;
      #2 srst = 1'b0;
      #1;
      m_reset();
      check_all();
      @(posedge sclk);
   endtask

   initial begin
      srst = 1'b0; sena = 0; xopc = NOP; xfn3 = 3'd0; xalu = '0; xrs2 = '0; dwb_ack = 0;
      m_reset();
      #2 check_all();

      // word load at 0x100, acknowledged on the third bus cycle
      cyc(1, LD, 3'b010, 32'h100, 32'h0, 0);
      cyc(0, NOP, 3'd0, 32'h0, 32'h0, 0);
      cyc(0, NOP, 3'd0, 32'h0, 32'h0, 0);
      cyc(0, NOP, 3'd0, 32'h0, 32'h0, 1);
      cyc(0, NOP, 3'd0, 32'h0, 32'h0, 0);

      // byte store to 0x203 with zero-wait acknowledge
      cyc(1, ST, 3'b000, 32'h203, 32'hA5, 0);
      cyc(0, NOP, 3'd0, 32'h0, 32'h0, 1);
      cyc(0, NOP, 3'd0, 32'h0, 32'h0, 0);

      // half loads: aligned at 0x302, misaligned at 0x301
      cyc(1, LD, 3'b001, 32'h302, 32'h0, 0);
      cyc(0, NOP, 3'd0, 32'h0, 32'h0, 1);
      cyc(1, LD, 3'b101, 32'h301, 32'h0, 0);
      cyc(0, NOP, 3'd0, 32'h0, 32'h0, 0);
      cyc(0, NOP, 3'd0, 32'h0, 32'h0, 0);
      // funct3 size 11 is never a legal access
      cyc(1, ST, 3'b011, 32'h400, 32'h1234, 0);
      cyc(0, NOP, 3'd0, 32'h0, 32'h0, 0);

      // back-to-back word loads, acknowledged every cycle
      cyc(1, LD, 3'b010, 32'h1000, 32'h0, 0);
      for (int i = 1; i <= 5; i++)
         cyc(1, LD, 3'b010, 32'h1000 + 32'(4 * i), 32'h0, 1);
      cyc(0, NOP, 3'd0, 32'h0, 32'h0, 1);
      cyc(0, NOP, 3'd0, 32'h0, 32'h0, 0);

      // no acknowledge at all: timeout and bus error
      cyc(1, ST, 3'b010, 32'h2000, 32'hDEADBEEF, 0);
      for (int i = 0; i < TMO + 3; i++) cyc(0, NOP, 3'd0, 32'h0, 32'h0, 0);

      // acknowledge on the last stalled cycle and on the abort cycle
      for (int late = TMO - 1; late <= TMO; late++) begin
         cyc(1, LD, 3'b010, 32'h3000, 32'h0, 0);
         for (int i = 0; i < late; i++) cyc(0, NOP, 3'd0, 32'h0, 32'h0, 0);
         cyc(0, NOP, 3'd0, 32'h0, 32'h0, 1);
         cyc(0, NOP, 3'd0, 32'h0, 32'h0, 0);
         cyc(0, NOP, 3'd0, 32'h0, 32'h0, 0);
      end

      // reset in the middle of a bus cycle, then a clean access
      cyc(1, ST, 3'b001, 32'h4002, 32'hBEEF, 0);
      cyc(0, NOP, 3'd0, 32'h0, 32'h0, 0);
      mid_reset();
      cyc(1, LD, 3'b000, 32'h5001, 32'h0, 0);
      cyc(0, NOP, 3'd0, 32'h0, 32'h0, 1);
      cyc(0, NOP, 3'd0, 32'h0, 32'h0, 0);

      // randomized run: alternating chatty and sluggish acknowledge phases
      for (int i = 0; i < 4000; i++) begin
         logic [4:0] opc;
         int r;
         int ack_pct;
         ack_pct = ((i / 500) % 2 == 0) ? 50 : 4;
         r = $urandom_range(0, 9);
         opc = (r < 4) ? LD : (r < 8) ? ST : 5'($urandom);
         if ($urandom_range(0, 399) == 0) mid_reset();
         cyc($urandom_range(0, 3) != 0, opc, 3'($urandom),
             $urandom, $urandom, $urandom_range(0, 99) < ack_pct);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
